// File: rtl/timer_master_pkg.sv
// timer_master_pkg
// Shared definitions for the system-clock interval-timer master:
//   - FSM state enum
//   - timer s1 register indices
//   - control-word bit positions and the start/stop control words
//   - the bus-beat struct and helpers that build one registered bus beat
package timer_master_pkg;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_WR_PL    = 4'd1,
    S_WR_PH    = 4'd2,
    S_WR_CTRL  = 4'd3,
    S_RUN      = 4'd4,
    S_CLR      = 4'd5,
    S_SNAP     = 4'd6,
    S_RD_L     = 4'd7,
    S_RD_H     = 4'd8,
    S_CAP      = 4'd9,
    S_WR_STOP  = 4'd10,
    S_STOP_CLR = 4'd11
  } state_t;

  // Timer s1 register indices
  localparam logic [2:0] TMR_STATUS   = 3'd0;
  localparam logic [2:0] TMR_CONTROL  = 3'd1;
  localparam logic [2:0] TMR_PERIOD_L = 3'd2;
  localparam logic [2:0] TMR_PERIOD_H = 3'd3;
  localparam logic [2:0] TMR_SNAP_L   = 3'd4;
  localparam logic [2:0] TMR_SNAP_H   = 3'd5;

  // Control register bit positions
  localparam int CTRL_ITO   = 0;
  localparam int CTRL_CONT  = 1;
  localparam int CTRL_START = 2;
  localparam int CTRL_STOP  = 3;

  localparam logic [15:0] CTRL_START_ONESHOT = (16'd1 << CTRL_ITO) | (16'd1 << CTRL_START);
  localparam logic [15:0] CTRL_START_CONT    = CTRL_START_ONESHOT | (16'd1 << CTRL_CONT);
  localparam logic [15:0] CTRL_STOP_WORD     = (16'd1 << CTRL_STOP);

  // One registered bus beat
  typedef struct packed {
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [15:0] writedata;
  } bus_t;

  localparam bus_t BUS_IDLE = '{address: 3'd0, chipselect: 1'b0, write_n: 1'b1, writedata: 16'h0000};

  function automatic logic [15:0] start_word(input logic cont);
    if (cont) begin
      return CTRL_START_CONT;
    end else begin
      return CTRL_START_ONESHOT;
    end
  endfunction

  function automatic bus_t bus_wr(input logic [2:0] addr, input logic [15:0] data);
    bus_t b;
    b.address    = addr;
    b.chipselect = 1'b1;
    b.write_n    = 1'b0;
    b.writedata  = data;
    return b;
  endfunction

  function automatic bus_t bus_rd(input logic [2:0] addr);
    bus_t b;
    b.address    = addr;
    b.chipselect = 1'b1;
    b.write_n    = 1'b1;
    b.writedata  = 16'h0000;
    return b;
  endfunction

endpackage

// File: rtl/nios_setup_v2_sys_clk_timer_master_if.sv
// nios_setup_v2_sys_clk_timer_master_if
// Avalon-MM link between the timer master and the interval timer's s1 port.
//   address/chipselect/write_n/writedata : master -> timer
//   readdata (registered, one cycle after address), irq : timer -> master
interface nios_setup_v2_sys_clk_timer_master_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;
  logic        irq;

  modport master (output address, chipselect, write_n, writedata, input readdata, irq);
  modport slave  (input address, chipselect, write_n, writedata, output readdata, irq);
endinterface

// File: rtl/nios_setup_v2_sys_clk_timer_master.sv
// nios_setup_v2_sys_clk_timer_master
// Programs the interval timer on start (period low/high, control), then services
// each timeout: clears status, snapshots the counter, reads it back and pulses tick.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   start, stop, period   control from fabric (start sampled in IDLE, stop latched)
//   bus                   Avalon-MM master view of the timer s1 port (+ irq)
//   busy, running         state != IDLE, state == RUN
//   tick, tick_count      one-cycle pulse per serviced timeout, wrapping count
//   snapshot, snap_valid  counter captured at last service, update strobe
module nios_setup_v2_sys_clk_timer_master
  import timer_master_pkg::*;
#(
  parameter logic CONTINUOUS = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic [31:0] period,
  nios_setup_v2_sys_clk_timer_master_if.master bus,
  output logic        busy,
  output logic        running,
  output logic        tick,
  output logic [15:0] tick_count,
  output logic [31:0] snapshot,
  output logic        snap_valid
);

  state_t      state_q, state_d;
  logic [31:0] period_q, period_d;
  logic        stop_latch_q, stop_latch_d;
  logic [15:0] snap_lo_q, snap_lo_d;
  bus_t        bus_q, bus_d;
  logic        busy_q, busy_d;
  logic        running_q, running_d;
  logic        tick_q, tick_d;
  logic [15:0] tick_count_q, tick_count_d;
  logic [31:0] snapshot_q, snapshot_d;
  logic        snap_valid_q, snap_valid_d;
  logic        start_acc_s;

  assign start_acc_s = (state_q == S_IDLE) && start;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (start) state_d = S_WR_PL; else state_d = S_IDLE;
      S_WR_PL:    state_d = S_WR_PH;
      S_WR_PH:    state_d = S_WR_CTRL;
      S_WR_CTRL:  state_d = S_RUN;
      S_RUN: begin
        // stop has priority over a simultaneous timeout
        if (stop || stop_latch_q) begin
          state_d = S_WR_STOP;
        end else if (bus.irq) begin
          state_d = S_CLR;
        end else begin
          state_d = S_RUN;
        end
      end
      S_CLR:      state_d = S_SNAP;
      S_SNAP:     state_d = S_RD_L;
      S_RD_L:     state_d = S_RD_H;
      S_RD_H:     state_d = S_CAP;
      S_CAP:      if (CONTINUOUS) state_d = S_RUN; else state_d = S_IDLE;
      S_WR_STOP:  state_d = S_STOP_CLR;
      S_STOP_CLR: state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Output/datapath decode: outputs are registered from the next state so they
  // line up with state_q in the same cycle
  always_comb begin
    if (start_acc_s) begin
      period_d = period;
    end else begin
      period_d = period_q;
    end

    case (state_d)
      S_WR_PL:    bus_d = bus_wr(TMR_PERIOD_L, period_d[15:0]);
      S_WR_PH:    bus_d = bus_wr(TMR_PERIOD_H, period_d[31:16]);
      S_WR_CTRL:  bus_d = bus_wr(TMR_CONTROL, start_word(CONTINUOUS));
      S_CLR:      bus_d = bus_wr(TMR_STATUS, 16'h0000);
      S_SNAP:     bus_d = bus_wr(TMR_SNAP_L, 16'h0000);
      S_RD_L:     bus_d = bus_rd(TMR_SNAP_L);
      S_RD_H:     bus_d = bus_rd(TMR_SNAP_H);
      S_WR_STOP:  bus_d = bus_wr(TMR_CONTROL, CTRL_STOP_WORD);
      S_STOP_CLR: bus_d = bus_wr(TMR_STATUS, 16'h0000);
      default:    bus_d = BUS_IDLE;
    endcase

    busy_d    = (state_d != S_IDLE);
    running_d = (state_d == S_RUN);
    tick_d    = (state_d == S_CLR);

    if (start_acc_s) begin
      tick_count_d = 16'h0000;
    end else if (state_d == S_CLR) begin
      tick_count_d = tick_count_q + 16'd1;
    end else begin
      tick_count_d = tick_count_q;
    end

    // readdata lags the address by one cycle: snap_l arrives during RD_H,
    // snap_h during CAP
    if (state_q == S_RD_H) begin
      snap_lo_d = bus.readdata;
    end else begin
      snap_lo_d = snap_lo_q;
    end

    if (state_q == S_CAP) begin
      snapshot_d   = {bus.readdata, snap_lo_q};
      snap_valid_d = 1'b1;
    end else begin
      snapshot_d   = snapshot_q;
      snap_valid_d = 1'b0;
    end

    // RUN consumes the latch; service states only accumulate it so the
    // service always completes before a stop is honoured
    if (state_q == S_IDLE || state_d == S_IDLE || state_q == S_RUN) begin
      stop_latch_d = 1'b0;
    end else begin
      stop_latch_d = stop_latch_q | stop;
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      period_q     <= 32'h0000_0000;
      stop_latch_q <= 1'b0;
      snap_lo_q    <= 16'h0000;
      bus_q        <= BUS_IDLE;
      busy_q       <= 1'b0;
      running_q    <= 1'b0;
      tick_q       <= 1'b0;
      tick_count_q <= 16'h0000;
      snapshot_q   <= 32'h0000_0000;
      snap_valid_q <= 1'b0;
    end else begin
      period_q     <= period_d;
      stop_latch_q <= stop_latch_d;
      snap_lo_q    <= snap_lo_d;
      bus_q        <= bus_d;
      busy_q       <= busy_d;
      running_q    <= running_d;
      tick_q       <= tick_d;
      tick_count_q <= tick_count_d;
      snapshot_q   <= snapshot_d;
      snap_valid_q <= snap_valid_d;
    end
  end

  assign bus.address    = bus_q.address;
  assign bus.chipselect = bus_q.chipselect;
  assign bus.write_n    = bus_q.write_n;
  assign bus.writedata  = bus_q.writedata;
  assign busy           = busy_q;
  assign running        = running_q;
  assign tick           = tick_q;
  assign tick_count     = tick_count_q;
  assign snapshot       = snapshot_q;
  assign snap_valid     = snap_valid_q;

endmodule
